bridge_actuator: RTL

- Downstream stage of the drawbridge controller.
- Consumes its raise, barrier and alert commands and sequences the physical outputs: barrier motor, deck up/down motor and warning lamp.
- Uses limit-switch and barrier-sensor feedback, with per-phase timeouts and a latched fault.
- Enforces the interlock: the deck never moves unless the barrier has been confirmed closed for a settle time.

---
 rtl/bridge_actuator.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bridge_actuator.sv
// Drawbridge actuator sequencer: drives barrier, deck motor and warning lamp from
// controller commands, with limit/barrier feedback, per-phase timeouts and a latched fault.
module bridge_actuator #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int BLINK_HALF     = 8,
    parameter int TW             = 7
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_bridge_req,
    input  logic       i_barrier_req,
    input  logic       i_alert_req,
    input  logic       i_barrier_down,
    input  logic       i_limit_up,
    input  logic       i_limit_down,
    output logic       o_barrier_close,
    output logic       o_motor_up,
    output logic       o_motor_down,
    output logic       o_lamp,
    output logic       o_fault,
    output logic [2:0] o_deck_state
);
    localparam logic [2:0] DOWN_OPEN     = 3'b000;
    localparam logic [2:0] BARRIER_CLOSE = 3'b001;
    localparam logic [2:0] RAISING       = 3'b010;
    localparam logic [2:0] UP            = 3'b011;
    localparam logic [2:0] LOWERING      = 3'b100;
    localparam logic [2:0] FAULT         = 3'b111;

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [TW-1:0] SETTLE_V   = TW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_V  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    logic [2:0]    state_r, nextState_s;
    logic [TW-1:0] timer_r, timerNext_s;
    logic [TW-1:0] settle_r, settleNext_s;
    logic [BW-1:0] blinkCnt_r, blinkNext_s;
    logic          lampPhase_r, phaseNext_s;
    logic          globalFault_s, timeout_s, settled_s, lampNext_s;

    // Next-state selection; global fault conditions override every other transition.
    always_comb begin
        nextState_s   = state_r;
        timeout_s     = (timer_r == TIMEOUT_V);
        settled_s     = (settle_r == SETTLE_V);
        globalFault_s = (i_limit_up & i_limit_down) |
                        (~i_barrier_down & ((state_r == RAISING) | (state_r == UP) |
                                            (state_r == LOWERING)));
        if (globalFault_s) begin
            nextState_s = FAULT;
        end else begin
            case (state_r)
                DOWN_OPEN: begin
                    if (i_bridge_req | i_barrier_req) nextState_s = BARRIER_CLOSE;
                    else                               nextState_s = DOWN_OPEN;
                end
                BARRIER_CLOSE: begin
                    if (!i_bridge_req && !i_barrier_req) nextState_s = DOWN_OPEN;
                    else if (settled_s && i_bridge_req)  nextState_s = RAISING;
                    else if (timeout_s && !settled_s)    nextState_s = FAULT;
                    else                                  nextState_s = BARRIER_CLOSE;
                end
                // Completion is tested before timeout so a coincident limit wins.
                RAISING: begin
                    if (i_limit_up)     nextState_s = UP;
                    else if (timeout_s) nextState_s = FAULT;
                    else                nextState_s = RAISING;
                end
                UP: begin
                    if (!i_bridge_req) nextState_s = LOWERING;
                    else               nextState_s = UP;
                end
                LOWERING: begin
                    if (i_limit_down)   nextState_s = BARRIER_CLOSE;
                    else if (timeout_s) nextState_s = FAULT;
                    else                nextState_s = LOWERING;
                end
                FAULT:   nextState_s = FAULT;
                default: nextState_s = FAULT;
            endcase
        end
    end

    // Phase timer and barrier settle counter; both restart on every state change.
    always_comb begin
        timerNext_s  = timer_r;
        settleNext_s = settle_r;
        if (nextState_s != state_r) begin
            timerNext_s  = {TW{1'b0}};
            settleNext_s = {TW{1'b0}};
        end else begin
            if (timer_r != TIMER_MAX) timerNext_s = timer_r + {{(TW-1){1'b0}}, 1'b1};
            else                      timerNext_s = timer_r;
            if (state_r != BARRIER_CLOSE || !i_barrier_down) settleNext_s = {TW{1'b0}};
            else if (!settled_s) settleNext_s = settle_r + {{(TW-1){1'b0}}, 1'b1};
            else                 settleNext_s = settle_r;
        end
    end

    // Free-running blink source and lamp decode against the upcoming state.
    always_comb begin
        blinkNext_s = blinkCnt_r;
        phaseNext_s = lampPhase_r;
        lampNext_s  = 1'b0;
        if (blinkCnt_r == BLINK_LAST) begin
            blinkNext_s = {BW{1'b0}};
            phaseNext_s = ~lampPhase_r;
        end else begin
            blinkNext_s = blinkCnt_r + {{(BW-1){1'b0}}, 1'b1};
            phaseNext_s = lampPhase_r;
        end
        if (nextState_s == FAULT) lampNext_s = 1'b1;
        else if (i_alert_req || nextState_s == RAISING || nextState_s == LOWERING)
            lampNext_s = phaseNext_s;
        else
            lampNext_s = 1'b0;
    end

    // State, counters and Moore outputs registered together so outputs track the state.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r         <= DOWN_OPEN;
            timer_r         <= {TW{1'b0}};
            settle_r        <= {TW{1'b0}};
            blinkCnt_r      <= {BW{1'b0}};
            lampPhase_r     <= 1'b0;
            o_barrier_close <= 1'b0;
            o_motor_up      <= 1'b0;
            o_motor_down    <= 1'b0;
            o_lamp          <= 1'b0;
            o_fault         <= 1'b0;
        end else begin
            state_r         <= nextState_s;
            timer_r         <= timerNext_s;
            settle_r        <= settleNext_s;
            blinkCnt_r      <= blinkNext_s;
            lampPhase_r     <= phaseNext_s;
            o_barrier_close <= (nextState_s != DOWN_OPEN);
            o_motor_up      <= (nextState_s == RAISING);
            o_motor_down    <= (nextState_s == LOWERING);
            o_lamp          <= lampNext_s;
            o_fault         <= (nextState_s == FAULT);
        end
    end

    assign o_deck_state = state_r;

endmodule
